zx_tape_player: RTL and testbench
=================================

Name: zx_tape_player

Overview:
- Sequences playback of a .P program image held in external SRAM into a ZX81-format tape pulse stream for the zx01 tape input.
- Started by the play button; fetches bytes over a req/ack memory port shared with the SRAM arbiter; emits MSB-first bit pulse trains.
- Runs in the 6.5 MHz core clock domain, alongside the existing EAR conditioning logic.
- The top level ORs or muxes tape_out with conditioned EAR; that mux is outside this block.

Parameters:
- ADDR_W, 14: byte address / length width (16 KB buffer).
- PULSE_HI_CYC, 975: high time of one pulse in clk cycles (150 us at 6.5 MHz).
- PULSE_LO_CYC, 975: low time of one pulse.
- GAP_CYC, 8450: silence after each bit (1300 us).
- LEADER_CYC, 6500000: silence before the first byte and after the last byte (1 s).
- CNT_W, 23: timer width; must hold max(LEADER_CYC, GAP_CYC).

Ports:
- clk, in, 1: core clock, 6.5 MHz.
- reset, in, 1: synchronous, active-high.
- play, in, 1: start request, level input; rising-edge detected internally.
- stop, in, 1: synchronous abort, level input.
- length, in, ADDR_W: number of bytes to play; sampled on start.
- mem_req, out, 1: memory read request.
- mem_addr, out, ADDR_W: byte address being read.
- mem_ack, in, 1: one-cycle acknowledge; mem_data is valid in the same cycle.
- mem_data, in, 8: read data.
- tape_out, out, 1: pulse stream; high = pulse.
- busy, out, 1: high in every state except IDLE.
- done, out, 1: one-cycle pulse on normal completion.

Behaviour:
- Reset values: state IDLE, tape_out 0, mem_req 0, mem_addr 0, busy 0, done 0, all counters 0. The play edge register resets to 1, so play held high through reset does not start playback.
- All outputs are registered.
- States: IDLE, LEADER, FETCH, PULSE_HI, PULSE_LO, GAP, TRAIL.
- IDLE:
  - On a play rising edge with length != 0: latch length, set mem_addr = 0, go to LEADER, busy = 1 on the next cycle.
  - On a play rising edge with length == 0: done = 1 on the next cycle, stay in IDLE, no output activity.
- LEADER: tape_out 0 for exactly LEADER_CYC cycles, then FETCH.
- FETCH:
  - mem_req = 1 with mem_addr stable, held until mem_ack.
  - On the ack cycle, capture mem_data into the shift register; mem_req = 0 from the next cycle.
  - Set bit index to 7, load pulse count (9 if bit7 = 1, else 4), go to PULSE_HI.
  - mem_ack arriving while mem_req = 0 is ignored.
- PULSE_HI: tape_out 1 for PULSE_HI_CYC cycles, then PULSE_LO.
- PULSE_LO: tape_out 0 for PULSE_LO_CYC cycles; decrement pulse count. If the remaining count is nonzero go to PULSE_HI, else go to GAP.
- GAP: tape_out 0 for GAP_CYC cycles, then:
  - If bit index > 0: decrement it, load the pulse count for the next bit (MSB first), go to PULSE_HI.
  - Else if mem_addr == length-1: go to TRAIL.
  - Else: mem_addr += 1, go to FETCH.
- TRAIL: tape_out 0 for LEADER_CYC cycles, then IDLE with done = 1 for exactly one cycle and busy = 0.
- Timer: counts 0..N-1 per timed state. N includes the state-entry cycle, so a state lasts exactly N cycles.
- stop = 1 in any non-IDLE state: next cycle IDLE, tape_out 0, mem_req 0, busy 0, no done. stop has priority over every other transition, including a same-cycle mem_ack. stop in IDLE has no effect, and a play edge coinciding with stop is ignored.
- A play edge while busy is ignored; length changes while busy are ignored.
- Reset mid-operation behaves as stop and additionally clears mem_addr.
- mem_addr is not wrapped: length == 2^ADDR_W-1 is the maximum playable length, because length is ADDR_W bits.
- Cycles per byte: 8*GAP_CYC + (pulses)*(PULSE_HI_CYC + PULSE_LO_CYC) + fetch latency. Pulses are 4 per 0-bit and 9 per 1-bit.

Test Plan:
- Common setup for all scenarios: PULSE_HI_CYC = PULSE_LO_CYC = 4, GAP_CYC = 20, LEADER_CYC = 10, ack one cycle after req.
- Single byte: length = 1, mem[0] = 0x80, play edge.
  - Required: tape_out low 10 cycles, then 9 pulses (4 high / 4 low), a 20-cycle gap, then 7 groups of 4 pulses, each group followed by a 20-cycle gap.
  - 37 high pulses total, trail of 10, one done pulse, busy low afterwards.
- Two bytes: length = 2, mem = {0xFF, 0x00}.
  - Required: exactly 2 mem_req transactions, at addresses 0 and 1.
  - 72 pulses then 32 pulses, 104 total; mem_req is never high during pulses.
- Ack stall: mem_ack delayed 7 cycles.
  - Required: mem_req and mem_addr held stable for those 7 cycles, tape_out 0, and the pulse output is otherwise identical to the single-byte case.
- Abort: stop asserted during the 3rd pulse of byte 0.
  - Required: next cycle tape_out 0, busy 0, mem_req 0; done never pulses.
  - A new play edge restarts playback from address 0 with a full leader.
- Edge cases:
  - length = 0 with a play edge gives done after one cycle, no pulses, busy stays 0.
  - play held high across reset release does not start playback.
  - A play edge while busy does not restart playback.

Source files
------------

// File: rtl/zx_tape_player_if.sv
// Memory read port between the tape player and the SRAM arbiter.
// mem_ack is a one-cycle strobe; mem_data is valid in the same cycle.
interface zx_tape_player_if #(
  parameter int ADDR_W = 14
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_data;

  modport master (output mem_req, mem_addr, input mem_ack, mem_data);
  modport slave  (input mem_req, mem_addr, output mem_ack, mem_data);
endinterface

// File: rtl/zx_tape_player.sv
// Plays a .P image from SRAM as a ZX81 tape pulse stream, MSB first.
//
// state     | meaning
// IDLE      | waiting for a play edge
// LEADER    | leading silence before the first byte
// FETCH     | memory read outstanding, waiting for mem_ack
// PULSE_HI  | high half of one pulse
// PULSE_LO  | low half of one pulse
// GAP       | silence after each bit
// TRAIL     | trailing silence after the last byte
module zx_tape_player #(
  parameter int ADDR_W       = 14,
  parameter int PULSE_HI_CYC = 975,
  parameter int PULSE_LO_CYC = 975,
  parameter int GAP_CYC      = 8450,
  parameter int LEADER_CYC   = 6500000,
  parameter int CNT_W        = 23
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               play,
  input  logic               stop,
  input  logic [ADDR_W-1:0]  length,
  zx_tape_player_if.master   mem,
  output logic               tape_out,
  output logic               busy,
  output logic               done
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LEADER   = 3'd1;
  localparam logic [2:0] S_FETCH    = 3'd2;
  localparam logic [2:0] S_PULSE_HI = 3'd3;
  localparam logic [2:0] S_PULSE_LO = 3'd4;
  localparam logic [2:0] S_GAP      = 3'd5;
  localparam logic [2:0] S_TRAIL    = 3'd6;

  // Down-counter load values: a state lasts load+1 cycles including entry.
  localparam logic [CNT_W-1:0] T_LEADER = CNT_W'(LEADER_CYC - 1);
  localparam logic [CNT_W-1:0] T_HI     = CNT_W'(PULSE_HI_CYC - 1);
  localparam logic [CNT_W-1:0] T_LO     = CNT_W'(PULSE_LO_CYC - 1);
  localparam logic [CNT_W-1:0] T_GAP    = CNT_W'(GAP_CYC - 1);

  logic [2:0]        state, state_nx;
  logic [CNT_W-1:0]  timer, timer_nx;
  logic [ADDR_W-1:0] addr_q, addr_nx;
  logic [ADDR_W-1:0] len_q, len_nx;
  logic [6:0]        rest_bits, rest_nx;
  logic [2:0]        bit_idx, bit_nx;
  logic [3:0]        pulse_cnt, pcnt_nx;
  logic              done_nx;
  logic              play_q;
  logic              mem_req_q;
  logic              play_edge;
  logic              tmr_end;

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = addr_q;
  assign play_edge    = play & ~play_q;
  assign tmr_end      = (timer == '0);

  always_comb begin
    state_nx = state;
    timer_nx = timer;
    addr_nx  = addr_q;
    len_nx   = len_q;
    rest_nx  = rest_bits;
    bit_nx   = bit_idx;
    pcnt_nx  = pulse_cnt;
    done_nx  = 1'b0;
    if (state != S_IDLE && stop) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (play_edge && !stop) begin
            if (length != '0) begin
              len_nx   = length;
              addr_nx  = '0;
              state_nx = S_LEADER;
              timer_nx = T_LEADER;
            end else begin
              done_nx = 1'b1;
            end
          end
        end
        S_LEADER: begin
          if (tmr_end) state_nx = S_FETCH;
          else         timer_nx = timer - CNT_W'(1);
        end
        S_FETCH: begin
          if (mem.mem_ack && mem_req_q) begin
            rest_nx  = mem.mem_data[6:0];
            bit_nx   = 3'd7;
            pcnt_nx  = mem.mem_data[7] ? 4'd9 : 4'd4;
            state_nx = S_PULSE_HI;
            timer_nx = T_HI;
          end
        end
        S_PULSE_HI: begin
          if (tmr_end) begin
            state_nx = S_PULSE_LO;
            timer_nx = T_LO;
          end else begin
            timer_nx = timer - CNT_W'(1);
          end
        end
        S_PULSE_LO: begin
          if (tmr_end) begin
            pcnt_nx = pulse_cnt - 4'd1;
            if (pulse_cnt != 4'd1) begin
              state_nx = S_PULSE_HI;
              timer_nx = T_HI;
            end else begin
              state_nx = S_GAP;
              timer_nx = T_GAP;
            end
          end else begin
            timer_nx = timer - CNT_W'(1);
          end
        end
        S_GAP: begin
          if (tmr_end) begin
            if (bit_idx != 3'd0) begin
              bit_nx   = bit_idx - 3'd1;
              rest_nx  = {rest_bits[5:0], 1'b0};
              pcnt_nx  = rest_bits[6] ? 4'd9 : 4'd4;
              state_nx = S_PULSE_HI;
              timer_nx = T_HI;
            end else if (addr_q == len_q - ADDR_W'(1)) begin
              state_nx = S_TRAIL;
              timer_nx = T_LEADER;
            end else begin
              addr_nx  = addr_q + ADDR_W'(1);
              state_nx = S_FETCH;
            end
          end else begin
            timer_nx = timer - CNT_W'(1);
          end
        end
        S_TRAIL: begin
          if (tmr_end) begin
            state_nx = S_IDLE;
            done_nx  = 1'b1;
          end else begin
            timer_nx = timer - CNT_W'(1);
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they stay registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      timer     <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      rest_bits <= '0;
      bit_idx   <= '0;
      pulse_cnt <= '0;
      play_q    <= 1'b1;
      mem_req_q <= 1'b0;
      tape_out  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      timer     <= timer_nx;
      addr_q    <= addr_nx;
      len_q     <= len_nx;
      rest_bits <= rest_nx;
      bit_idx   <= bit_nx;
      pulse_cnt <= pcnt_nx;
      play_q    <= play;
      mem_req_q <= (state_nx == S_FETCH);
      tape_out  <= (state_nx == S_PULSE_HI);
      busy      <= (state_nx != S_IDLE);
      done      <= done_nx;
    end
  end

endmodule

// File: tb/tb_zx_tape_player.sv
// Directed bench for zx_tape_player with shortened timing parameters.
module tb_zx_tape_player;
  localparam int AW   = 14;
  localparam int HI   = 4;
  localparam int LO   = 4;
  localparam int GAP  = 20;
  localparam int LEAD = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          play = 1'b0;
  logic          stop = 1'b0;
  logic [AW-1:0] length = '0;
  logic          tape_out, busy, done;

  zx_tape_player_if #(.ADDR_W(AW)) mem_bus ();

  zx_tape_player #(
    .ADDR_W(AW), .PULSE_HI_CYC(HI), .PULSE_LO_CYC(LO),
    .GAP_CYC(GAP), .LEADER_CYC(LEAD), .CNT_W(23)
  ) dut (
    .clk(clk), .reset(reset), .play(play), .stop(stop), .length(length),
    .mem(mem_bus), .tape_out(tape_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem_arr [0:3];
  int ack_delay = 1;

  bit cap_tape[$];
  bit exp_tape[$];
  int req_addrs[$];
  int req_cycles, addr_unstable, overlap, done_early, end_done, timed_out;

  // SRAM model: acks ack_delay cycles after the cycle req first appears.
  initial begin
    int req_cnt;
    req_cnt = 0;
    mem_bus.mem_ack  = 1'b0;
    mem_bus.mem_data = 8'h00;
    forever begin
      @(negedge clk);
      if (mem_bus.mem_ack) begin
        mem_bus.mem_ack = 1'b0;
        req_cnt = 0;
      end else if (mem_bus.mem_req) begin
        req_cnt++;
        if (req_cnt > ack_delay) begin
          mem_bus.mem_ack  = 1'b1;
          mem_bus.mem_data = mem_arr[mem_bus.mem_addr[1:0]];
        end
      end else begin
        req_cnt = 0;
      end
    end
  end

  task automatic build_exp(input int nbytes, input int lat);
    logic [7:0] b;
    int np;
    exp_tape.delete();
    repeat (LEAD) exp_tape.push_back(1'b0);
    for (int k = 0; k < nbytes; k++) begin
      b = mem_arr[k];
      repeat (lat) exp_tape.push_back(1'b0);
      for (int j = 7; j >= 0; j--) begin
        np = b[j] ? 9 : 4;
        repeat (np) begin
          repeat (HI) exp_tape.push_back(1'b1);
          repeat (LO) exp_tape.push_back(1'b0);
        end
        repeat (GAP) exp_tape.push_back(1'b0);
      end
    end
    repeat (LEAD) exp_tape.push_back(1'b0);
  endtask

  function automatic int first_diff();
    int n;
    n = (cap_tape.size() < exp_tape.size()) ? cap_tape.size() : exp_tape.size();
    for (int i = 0; i < n; i++) if (cap_tape[i] !== exp_tape[i]) return i;
    if (cap_tape.size() != exp_tape.size()) return n;
    return -1;
  endfunction

  function automatic int count_rises();
    int c;
    bit p;
    c = 0;
    p = 1'b0;
    for (int i = 0; i < cap_tape.size(); i++) begin
      if (cap_tape[i] && !p) c++;
      p = cap_tape[i];
    end
    return c;
  endfunction

  // Issues a play edge and records every busy cycle until busy drops.
  task automatic capture(input int budget, input int retrig);
    bit prev_req;
    logic [AW-1:0] prev_addr;
    cap_tape.delete();
    req_addrs.delete();
    req_cycles = 0; addr_unstable = 0; overlap = 0;
    done_early = 0; end_done = 0; timed_out = 1;
    prev_req = 1'b0;
    prev_addr = '0;
    @(negedge clk) play = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (i == 0) play = 1'b0;
      if (!busy) begin
        end_done = int'(done);
        timed_out = 0;
        break;
      end
      cap_tape.push_back(tape_out);
      if (done) done_early++;
      if (mem_bus.mem_req) begin
        req_cycles++;
        if (tape_out) overlap++;
        if (!prev_req) req_addrs.push_back(int'(mem_bus.mem_addr));
        else if (mem_bus.mem_addr !== prev_addr) addr_unstable++;
      end
      prev_req = mem_bus.mem_req;
      prev_addr = mem_bus.mem_addr;
      if (retrig > 0 && i == retrig) begin
        play = 1'b1;
        length = 14'd2;
      end
      if (retrig > 0 && i == retrig + 2) play = 1'b0;
    end
  endtask

  task automatic test_reset();
    int busy_seen;
    reset = 1'b1;
    play = 1'b1;
    length = 14'd1;
    repeat (3) @(negedge clk);
    checks++; if (tape_out !== 1'b0) begin errors++; $display("FAIL reset_tape got %b exp 0", tape_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (mem_bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", mem_bus.mem_req); end
    checks++; if (mem_bus.mem_addr !== 14'd0) begin errors++; $display("FAIL reset_addr got %0d exp 0", mem_bus.mem_addr); end
    reset = 1'b0;
    busy_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) busy_seen++;
    end
    checks++; if (busy_seen !== 0) begin errors++; $display("FAIL play_held_reset active_cycles got %0d exp 0", busy_seen); end
    play = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_byte();
    mem_arr[0] = 8'h80;
    ack_delay = 1;
    length = 14'd1;
    build_exp(1, 2);
    capture(2000, 0);
    checks++; if (timed_out !== 0) begin errors++; $display("FAIL single_timeout got %0d exp 0", timed_out); end
    checks++; if (cap_tape.size() !== 478) begin errors++; $display("FAIL single_cycles got %0d exp 478", cap_tape.size()); end
    checks++; if (first_diff() !== -1) begin errors++; $display("FAIL single_wave first_diff got %0d exp -1", first_diff()); end
    checks++; if (count_rises() !== 37) begin errors++; $display("FAIL single_pulses got %0d exp 37", count_rises()); end
    checks++; if (end_done !== 1 || done_early !== 0) begin errors++; $display("FAIL single_done got end=%0d early=%0d exp 1/0", end_done, done_early); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_after got done=%b busy=%b exp 0/0", done, busy); end
  endtask

  task automatic test_two_bytes();
    mem_arr[0] = 8'hFF;
    mem_arr[1] = 8'h00;
    ack_delay = 1;
    length = 14'd2;
    build_exp(2, 2);
    capture(3000, 0);
    checks++; if (cap_tape.size() !== 1176) begin errors++; $display("FAIL two_cycles got %0d exp 1176", cap_tape.size()); end
    checks++; if (first_diff() !== -1) begin errors++; $display("FAIL two_wave first_diff got %0d exp -1", first_diff()); end
    checks++; if (count_rises() !== 104) begin errors++; $display("FAIL two_pulses got %0d exp 104", count_rises()); end
    checks++; if (req_addrs.size() !== 2) begin errors++; $display("FAIL two_req_count got %0d exp 2", req_addrs.size()); end
    else begin
      checks++; if (req_addrs[0] !== 0 || req_addrs[1] !== 1) begin errors++; $display("FAIL two_req_addr got %0d,%0d exp 0,1", req_addrs[0], req_addrs[1]); end
    end
    checks++; if (overlap !== 0) begin errors++; $display("FAIL two_req_during_pulse got %0d exp 0", overlap); end
    checks++; if (end_done !== 1) begin errors++; $display("FAIL two_done got %0d exp 1", end_done); end
  endtask

  task automatic test_ack_stall();
    mem_arr[0] = 8'h80;
    ack_delay = 7;
    length = 14'd1;
    build_exp(1, 8);
    capture(2000, 0);
    checks++; if (req_cycles !== 8) begin errors++; $display("FAIL stall_req_cycles got %0d exp 8", req_cycles); end
    checks++; if (addr_unstable !== 0 || overlap !== 0) begin errors++; $display("FAIL stall_stable got addr_chg=%0d tape_hi=%0d exp 0/0", addr_unstable, overlap); end
    checks++; if (first_diff() !== -1) begin errors++; $display("FAIL stall_wave first_diff got %0d exp -1", first_diff()); end
    checks++; if (end_done !== 1) begin errors++; $display("FAIL stall_done got %0d exp 1", end_done); end
    ack_delay = 1;
  endtask

  task automatic test_abort();
    int bad;
    mem_arr[0] = 8'h80;
    ack_delay = 1;
    length = 14'd1;
    @(negedge clk) play = 1'b1;
    @(negedge clk) play = 1'b0;
    repeat (29) @(negedge clk);
    checks++; if (tape_out !== 1'b1) begin errors++; $display("FAIL abort_in_pulse3 got %b exp 1", tape_out); end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checks++; if (tape_out !== 1'b0 || busy !== 1'b0 || mem_bus.mem_req !== 1'b0) begin
      errors++; $display("FAIL abort_outputs got tape=%b busy=%b req=%b exp 0/0/0", tape_out, busy, mem_bus.mem_req);
    end
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL abort_quiet got %0d exp 0", bad); end
    build_exp(1, 2);
    capture(2000, 0);
    checks++; if (first_diff() !== -1) begin errors++; $display("FAIL abort_restart_wave first_diff got %0d exp -1", first_diff()); end
    checks++; if (req_addrs.size() < 1 || req_addrs[0] !== 0) begin errors++; $display("FAIL abort_restart_addr got n=%0d exp first addr 0", req_addrs.size()); end
  endtask

  task automatic test_zero_length();
    int bad;
    length = 14'd0;
    @(negedge clk) play = 1'b1;
    @(negedge clk);
    play = 1'b0;
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL zero_done got done=%b busy=%b exp 1/0", done, busy); end
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || tape_out !== 1'b0 || mem_bus.mem_req !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL zero_quiet got %0d exp 0", bad); end
  endtask

  task automatic test_play_while_busy();
    mem_arr[0] = 8'h80;
    mem_arr[1] = 8'hFF;
    ack_delay = 1;
    length = 14'd1;
    build_exp(1, 2);
    capture(2000, 40);
    checks++; if (first_diff() !== -1) begin errors++; $display("FAIL retrig_wave first_diff got %0d exp -1", first_diff()); end
    checks++; if (req_addrs.size() !== 1) begin errors++; $display("FAIL retrig_req_count got %0d exp 1", req_addrs.size()); end
    checks++; if (end_done !== 1 || done_early !== 0) begin errors++; $display("FAIL retrig_done got end=%0d early=%0d exp 1/0", end_done, done_early); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_two_bytes();
    test_ack_stall();
    test_abort();
    test_zero_length();
    test_play_while_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
